fifo_drain_arbiter: RTL and testbench

//  Round-robin scheduler that drains N_CH fifo_2clk read ports (all on the read clock domain) into
//  one valid/ready stream, tagging each word with its source channel. Owns each FIFO's rd_en and

---
 rtl/fifo_drain_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_fifo_drain_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain of N_CH registered-read FIFOs into one channel-tagged valid/ready stream.
// Grants are held for at most MAX_BURST reads; a 2-entry buffer hides the FIFO read latency.

module fifo_drain_lane #(
    parameter int WIDTH = 8,
    parameter int CH_W  = 2,
    parameter int IDX   = 0
) (
    input  logic             issue_i,
    input  logic [CH_W-1:0]  issue_ch_i,
    input  logic [CH_W-1:0]  cap_ch_i,
    input  logic             empty_i,
    input  logic [WIDTH-1:0] dout_i,
    output logic             rd_en_o,
    output logic [WIDTH-1:0] dout_o
);
    localparam logic [CH_W-1:0] ID = CH_W'(IDX);

    // The empty gate guarantees the FIFO never sees an rd_en it would have to ignore
    assign rd_en_o = issue_i && (issue_ch_i == ID) && !empty_i;
    assign dout_o  = (cap_ch_i == ID) ? dout_i : '0;
endmodule

module fifo_drain_arbiter #(
    parameter int N_CH      = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst_sync,
    input  logic [N_CH-1:0]          ch_empty,
    output logic [N_CH-1:0]          ch_rd_en,
    input  logic [N_CH*WIDTH-1:0]    ch_dout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(N_CH)-1:0]  out_chan
);
    localparam int CH_W = $clog2(N_CH);
    localparam int BC_W = $clog2(MAX_BURST + 1);
    localparam logic [BC_W-1:0] BURST_MAX = BC_W'(MAX_BURST);
    localparam logic [CH_W-1:0] LAST_CH   = CH_W'(N_CH - 1);

    typedef enum logic {IDLE, BURST} state_e;

    typedef struct packed {
        logic [CH_W-1:0]  chan;
        logic [WIDTH-1:0] data;
    } entry_t;

    state_e          state_q;
    logic [CH_W-1:0] rr_ptr_q;
    logic [CH_W-1:0] grant_q;
    logic [BC_W-1:0] burst_cnt_q;
    logic            infl_q;
    logic [CH_W-1:0] infl_ch_q;

    entry_t          ent0_q, ent1_q, ent0_d, ent1_d;
    logic [1:0]      vld_q, vld_d;

    logic            pop, push, space_ok, scan_hit, issue, burst_end;
    logic [1:0]      occ;
    logic [2:0]      fill;
    logic [CH_W-1:0] scan_ch, issue_ch;
    logic [WIDTH-1:0] cap_data;
    logic [N_CH-1:0][WIDTH-1:0] lane_dout;

    assign pop      = vld_q[0] && out_ready;
    assign push     = infl_q;
    assign occ      = {1'b0, vld_q[0]} + {1'b0, vld_q[1]};
    assign fill     = 3'(occ) + 3'(infl_q) - 3'(pop);
    assign space_ok = fill < 3'd2;

    // First non-empty channel at or after rr_ptr; descending k so the nearest hit wins
    always_comb begin
        scan_hit = 1'b0;
        scan_ch  = rr_ptr_q;
        for (int k = N_CH - 1; k >= 0; k--) begin
            automatic int s = int'(rr_ptr_q) + k;
            if (s >= N_CH) s = s - N_CH;
            if (!ch_empty[CH_W'(s)]) begin
                scan_hit = 1'b1;
                scan_ch  = CH_W'(s);
            end
        end
    end

    always_comb begin
        issue     = 1'b0;
        issue_ch  = grant_q;
        burst_end = 1'b0;
        if (!rst_sync) begin
            case (state_q)
                IDLE: begin
                    if (scan_hit && space_ok) begin
                        issue    = 1'b1;
                        issue_ch = scan_ch;
                    end
                end
                BURST: begin
                    if (ch_empty[grant_q] || burst_cnt_q == BURST_MAX) burst_end = 1'b1;
                    else if (space_ok)                                    issue     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        fifo_drain_lane #(
            .WIDTH (WIDTH),
            .CH_W  (CH_W),
            .IDX   (i)
        ) u_lane (
            .issue_i    (issue),
            .issue_ch_i (issue_ch),
            .cap_ch_i   (infl_ch_q),
            .empty_i    (ch_empty[i]),
            .dout_i     (ch_dout[i*WIDTH +: WIDTH]),
            .rd_en_o    (ch_rd_en[i]),
            .dout_o     (lane_dout[i])
        );
    end

    always_comb begin
        cap_data = '0;
        for (int i = 0; i < N_CH; i++) cap_data = cap_data | lane_dout[i];
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            burst_cnt_q <= '0;
            infl_q      <= 1'b0;
            infl_ch_q   <= '0;
        end else begin
            infl_q    <= issue;
            infl_ch_q <= issue_ch;
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        grant_q     <= issue_ch;
                        burst_cnt_q <= BC_W'(1);
                        state_q     <= BURST;
                    end
                end
                BURST: begin
                    if (burst_end) begin
                        rr_ptr_q    <= (grant_q == LAST_CH) ? '0 : grant_q + CH_W'(1);
                        burst_cnt_q <= '0;
                        state_q     <= IDLE;
                    end else if (issue) begin
                        burst_cnt_q <= burst_cnt_q + BC_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Head lives in ent0; a pop shifts ent1 forward so out_* come straight from a flop
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        vld_d  = vld_q;
        case ({push, pop})
            2'b10: begin
                if (!vld_q[0]) begin
                    ent0_d   = '{chan: infl_ch_q, data: cap_data};
                    vld_d[0] = 1'b1;
                end else begin
                    ent1_d   = '{chan: infl_ch_q, data: cap_data};
                    vld_d[1] = 1'b1;
                end
            end
            2'b01: begin
                if (vld_q[1]) ent0_d = ent1_q;
                vld_d = {1'b0, vld_q[1]};
            end
            2'b11: begin
                if (vld_q[1]) begin
                    ent0_d = ent1_q;
                    ent1_d = '{chan: infl_ch_q, data: cap_data};
                end else begin
                    ent0_d = '{chan: infl_ch_q, data: cap_data};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            ent0_q <= '0;
            ent1_q <= '0;
            vld_q  <= '0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            vld_q  <= vld_d;
        end
    end

    assign out_valid = vld_q[0];
    assign out_data  = ent0_q.data;
    assign out_chan  = ent0_q.chan;
endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Bench for fifo_drain_arbiter: queue-based FIFO models, cycle tables, corner sequences and
// a randomized run scored per channel against the words actually loaded.

module tb_fifo_drain_arbiter;
    localparam int N_CH = 4;
    localparam int W    = 8;

    typedef struct {
        int         ld_ch;
        int         ld_n;
        logic [7:0] ld_base;
        logic [7:0] ld_step;
        logic       rdy;
        logic [3:0] rd;
        logic       v;
        logic [1:0] c;
        logic [7:0] d;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_sync = 1'b1;
    logic            out_ready = 1'b0;
    logic            out_valid;
    logic [N_CH-1:0] ch_empty = '1;
    logic [N_CH-1:0] ch_rd_en;
    logic [N_CH*W-1:0] ch_dout = '0;
    logic [W-1:0]    out_data;
    logic [1:0]      out_chan;

    int checks = 0;
    int failures = 0;
    int viol = 0;
    int cyc = 0;

    logic [W-1:0] fq [N_CH][$];
    logic [W-1:0] exp_q [N_CH][$];
    logic [1:0]   got_c [$];
    logic [W-1:0] got_d [$];
    int           got_t [$];

    vec_t tbl [19];
    int e5c [8] = '{1, 1, 1, 1, 2, 2, 1, 1};
    int e5d [8] = '{'h51, 'h52, 'h53, 'h54, 'h61, 'h62, 'h55, 'h56};
    int e6c [4] = '{1, 1, 3, 3};
    int e6d [4] = '{'h81, 'h82, 'h91, 'h92};

    always #5 clk = ~clk;

    fifo_drain_arbiter #(.N_CH(N_CH), .WIDTH(W), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_sync  (rst_sync),
        .ch_empty  (ch_empty),
        .ch_rd_en  (ch_rd_en),
        .ch_dout   (ch_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_chan  (out_chan)
    );

    // Registered-read FIFO models; any rd_en on an empty FIFO or two rd_en at once is a violation
    always @(posedge clk) begin
        if ($countones(ch_rd_en) > 1) viol++;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_rd_en[i]) begin
                if (fq[i].size() == 0) viol++;
                else ch_dout[i*W +: W] <= fq[i].pop_front();
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < N_CH; i++) ch_empty[i] = (fq[i].size() == 0);
    endtask

    task automatic load(input int ch, input logic [7:0] d);
        fq[ch].push_back(d);
        exp_q[ch].push_back(d);
        refresh();
    endtask

    task automatic clear_log();
        got_c.delete();
        got_d.delete();
        got_t.delete();
    endtask

    task automatic tick();
        logic       stall;
        logic [7:0] sd;
        logic [1:0] sc;
        stall = out_valid && !out_ready && !rst_sync;
        sd = out_data;
        sc = out_chan;
        if (out_valid && out_ready && !rst_sync) begin
            got_c.push_back(out_chan);
            got_d.push_back(out_data);
            got_t.push_back(cyc);
        end
        @(negedge clk);
        refresh();
        if (stall && !rst_sync)
            check("stall_hold", 32'({out_valid, out_chan, out_data}), 32'({1'b1, sc, sd}));
        cyc++;
    endtask

    task automatic collect(input int n, input int budget, input string nm);
        int k;
        k = 0;
        while (got_c.size() < n && k < budget) begin
            tick();
            k++;
        end
        check({nm, "_count"}, 32'(got_c.size()), 32'(n));
    endtask

    initial begin
        // T4 backpressure rows, then T2 single-channel rows
        tbl[0]  = '{0, 6, 8'hA0, 8'h01, 1'b0, 4'b0001, 1'b0, 2'd0, 8'h00};
        tbl[1]  = '{0, 0, 8'h00, 8'h00, 1'b0, 4'b0001, 1'b0, 2'd0, 8'h00};
        tbl[2]  = '{0, 0, 8'h00, 8'h00, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA0};
        tbl[3]  = '{0, 0, 8'h00, 8'h00, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA0};
        tbl[4]  = '{0, 0, 8'h00, 8'h00, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA0};
        tbl[5]  = '{0, 0, 8'h00, 8'h00, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
        tbl[6]  = '{0, 0, 8'h00, 8'h00, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA1};
        tbl[7]  = '{0, 0, 8'h00, 8'h00, 1'b1, 4'b0000, 1'b1, 2'd0, 8'hA2};
        tbl[8]  = '{0, 0, 8'h00, 8'h00, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA3};
        tbl[9]  = '{0, 0, 8'h00, 8'h00, 1'b1, 4'b0001, 1'b0, 2'd0, 8'h00};
        tbl[10] = '{0, 0, 8'h00, 8'h00, 1'b1, 4'b0000, 1'b1, 2'd0, 8'hA4};
        tbl[11] = '{0, 0, 8'h00, 8'h00, 1'b1, 4'b0000, 1'b1, 2'd0, 8'hA5};
        tbl[12] = '{0, 0, 8'h00, 8'h00, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
        tbl[13] = '{2, 3, 8'h11, 8'h11, 1'b1, 4'b0100, 1'b0, 2'd0, 8'h00};
        tbl[14] = '{0, 0, 8'h00, 8'h00, 1'b1, 4'b0100, 1'b0, 2'd0, 8'h00};
        tbl[15] = '{0, 0, 8'h00, 8'h00, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h11};
        tbl[16] = '{0, 0, 8'h00, 8'h00, 1'b1, 4'b0000, 1'b1, 2'd2, 8'h22};
        tbl[17] = '{0, 0, 8'h00, 8'h00, 1'b1, 4'b0000, 1'b1, 2'd2, 8'h33};
        tbl[18] = '{0, 0, 8'h00, 8'h00, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};

        // T1: reset held with every channel non-empty
        for (int i = 0; i < N_CH; i++) load(i, 8'(8'hE0 + i));
        for (int r = 0; r < 2; r++) begin
            tick();
            check("rst_rd_en", 32'(ch_rd_en), 32'(0));
            check("rst_valid", 32'(out_valid), 32'(0));
            check("rst_data", 32'(out_data), 32'(0));
            check("rst_chan", 32'(out_chan), 32'(0));
        end
        for (int i = 0; i < N_CH; i++) fq[i].delete();
        refresh();
        rst_sync = 1'b0;

        for (int r = 0; r < 19; r++) begin
            for (int k = 0; k < tbl[r].ld_n; k++)
                load(tbl[r].ld_ch, 8'(tbl[r].ld_base + 8'(k) * tbl[r].ld_step));
            out_ready = tbl[r].rdy;
            #1;
            check($sformatf("vec%0d_rd_en", r), 32'(ch_rd_en), 32'(tbl[r].rd));
            check($sformatf("vec%0d_valid", r), 32'(out_valid), 32'(tbl[r].v));
            if (tbl[r].v) begin
                check($sformatf("vec%0d_chan", r), 32'(out_chan), 32'(tbl[r].c));
                check($sformatf("vec%0d_data", r), 32'(out_data), 32'(tbl[r].d));
            end
            tick();
        end

        // T5: pointer sits at 3 after the ch2 burst; scan 3,0,1 picks ch1, then ch2 is next
        clear_log();
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) load(1, 8'(8'h51 + k));
        for (int k = 0; k < 2; k++) load(2, 8'(8'h61 + k));
        collect(8, 60, "wrap");
        for (int k = 0; k < 8; k++) begin
            if (k < got_c.size()) begin
                check($sformatf("wrap%0d_chan", k), 32'(got_c[k]), 32'(e5c[k]));
                check($sformatf("wrap%0d_data", k), 32'(got_d[k]), 32'(e5d[k]));
            end
        end

        // T3: two full channels alternate in bursts of 4 with one bubble per rotation
        clear_log();
        for (int k = 0; k < 8; k++) load(0, 8'(k));
        for (int k = 0; k < 8; k++) load(1, 8'(8'h10 + k));
        collect(16, 80, "fair");
        for (int k = 0; k < 16; k++) begin
            if (k < got_c.size()) begin
                check($sformatf("fair%0d_chan", k), 32'(got_c[k]), 32'((k / 4) % 2));
                check($sformatf("fair%0d_data", k), 32'(got_d[k]),
                      32'(((k / 4) % 2) * 16 + (k / 8) * 4 + (k % 4)));
            end
        end
        if (got_t.size() >= 16)
            check("fair_span", 32'(got_t[15] - got_t[0] + 1), 32'(19));

        // T6: reset while the buffer holds a word and another read is in flight
        clear_log();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) load(3, 8'(8'h71 + k));
        tick();
        tick();
        #1;
        check("pre_rst_valid", 32'(out_valid), 32'(1));
        check("pre_rst_rd_en", 32'(ch_rd_en), 32'(0));
        rst_sync = 1'b1;
        for (int i = 0; i < N_CH; i++) fq[i].delete();
        refresh();
        tick();
        check("midrst_valid", 32'(out_valid), 32'(0));
        check("midrst_data", 32'({out_chan, out_data}), 32'(0));
        check("midrst_rd_en", 32'(ch_rd_en), 32'(0));
        rst_sync = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) load(1, 8'(8'h81 + k));
        for (int k = 0; k < 2; k++) load(3, 8'(8'h91 + k));
        collect(4, 40, "refill");
        for (int k = 0; k < 4; k++) begin
            if (k < got_c.size()) begin
                check($sformatf("refill%0d_chan", k), 32'(got_c[k]), 32'(e6c[k]));
                check($sformatf("refill%0d_data", k), 32'(got_d[k]), 32'(e6d[k]));
            end
        end
        for (int k = 0; k < 6; k++) tick();
        check("refill_extra", 32'(got_c.size()), 32'(4));

        // Randomized traffic: every loaded word must come out once, in per-channel order
        clear_log();
        for (int i = 0; i < N_CH; i++) exp_q[i].delete();
        begin
            int total;
            total = 0;
            for (int t = 0; t < 1500; t++) begin
                for (int i = 0; i < N_CH; i++) begin
                    if ($urandom_range(3) == 0 && fq[i].size() < 16) begin
                        load(i, 8'($urandom));
                        total++;
                    end
                end
                out_ready = ($urandom_range(3) != 0);
                tick();
            end
            out_ready = 1'b1;
            collect(total, 400, "rand_drain");
            for (int k = 0; k < got_c.size(); k++) begin
                if (exp_q[got_c[k]].size() == 0) begin
                    check($sformatf("rand%0d_dup", k), 32'(1), 32'(0));
                end else begin
                    check($sformatf("rand%0d_ch%0d", k, got_c[k]), 32'(got_d[k]),
                          32'(exp_q[got_c[k]].pop_front()));
                end
            end
        end

        check("rd_en_violations", 32'(viol), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
